counter_4: RTL and testbench



---
 rtl/counter_4.sv | 73 +++++++
 tb/tb_counter_4.sv | 125 ++++++++++++
 2 files changed

// File: rtl/counter_4.sv
// counter_4: 4-bit ping-pong (triangle) counter, 0..15..0, dwelling one cycle at each end (32-cycle period).
// Optional COUNTER4_STATUS_EN adds the dir/turn status outputs.
module counter_4 (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] out
`ifdef COUNTER4_STATUS_EN
    ,
    output logic       dir,
    output logic       turn
`endif
);

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_count;
    logic [3:0]  w_count_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_UP;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // At an endpoint the count holds and only the direction flips, so the
    // endpoint value appears twice and the count never wraps.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            ST_UP: begin
                if (r_count == 4'hF) w_state_next = ST_DOWN;
                else                 w_count_next = r_count + 4'd1;
            end
            ST_DOWN: begin
                if (r_count == 4'h0) w_state_next = ST_UP;
                else                 w_count_next = r_count - 4'd1;
            end
            default: begin
                w_state_next = ST_UP;
                w_count_next = '0;
            end
        endcase
    end

    assign out = r_count;

`ifdef COUNTER4_STATUS_EN
    logic r_turn;
    logic w_hold;

    // A direction change is exactly a hold edge; turn flags the repeated cycle.
    assign w_hold = (w_state_next != r_state);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_turn <= 1'b0;
        else        r_turn <= w_hold;
    end

    assign dir  = (r_state == ST_UP);
    assign turn = r_turn;
`endif

endmodule

// File: tb/tb_counter_4.sv
// Self-checking bench for counter_4: directed reset/ascent/dwell/mid-reset vectors plus a long triangle run.
// Status outputs are checked only when COUNTER4_STATUS_EN is defined.
module tb_counter_4;

    logic       clock;
    logic       reset;
    logic [3:0] out;
`ifdef COUNTER4_STATUS_EN
    logic       dir;
    logic       turn;
`endif

    int unsigned tests_run;
    int unsigned tests_failed;
    logic [3:0]  prev;

    counter_4 dut (
        .clock (clock),
        .reset (reset),
        .out   (out)
`ifdef COUNTER4_STATUS_EN
        ,
        .dir   (dir),
        .turn  (turn)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Triangle reference: n = edges since reset release.
    function automatic logic [3:0] tri_val(input int unsigned n);
        int unsigned p;
        p = n % 32;
        if (p < 16) return 4'(p);
        return 4'(31 - p);
    endfunction

    task automatic check_status(input string tag, input int unsigned n);
`ifdef COUNTER4_STATUS_EN
        int unsigned p;
        p = n % 32;
        check({tag, "_dir"}, {31'd0, dir}, {31'd0, (p < 16)});
        check({tag, "_turn"}, {31'd0, turn}, {31'd0, (p == 16) || (p == 0 && n != 0)});
`else
        if (tag.len() == 0 && n == 0) $display("status check skipped");
`endif
    endtask

    task automatic edge_check(input string tag, input int unsigned n);
        @(posedge clock);
        #1;
        check(tag, {28'd0, out}, {28'd0, tri_val(n)});
        check("no_wrap", {31'd0, ((prev == 4'hF && out == 4'h0) || (prev == 4'h0 && out == 4'hF))}, 32'd0);
        check_status(tag, n);
        prev = out;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        prev         = 4'h0;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1;
        check("reset_async", {28'd0, out}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_held", {28'd0, out}, 32'd0);
        check_status("reset", 0);

        @(negedge clock) reset = 1'b1;

        // Ascent, top dwell, descent, bottom dwell, restart
        for (int unsigned n = 1; n <= 33; n++) begin
            edge_check("period", n);
            case (n)
                1:  check("first_edge",  {28'd0, out}, 32'd1);
                15: check("asc_top",     {28'd0, out}, 32'd15);
                16: check("top_dwell",   {28'd0, out}, 32'd15);
                17: check("top_leave",   {28'd0, out}, 32'd14);
                31: check("desc_bottom", {28'd0, out}, 32'd0);
                32: check("bot_dwell",   {28'd0, out}, 32'd0);
                33: check("restart",     {28'd0, out}, 32'd1);
                default: ;
            endcase
        end

        // Reset mid-descent at out=9 (edge 22 of a fresh period)
        @(negedge clock) reset = 1'b0;
        #1;
        @(negedge clock) reset = 1'b1;
        prev = 4'h0;
        for (int unsigned n = 1; n <= 22; n++) edge_check("to_nine", n);
        check("at_nine", {28'd0, out}, 32'd9);
        #3 reset = 1'b0;
        #1;
        check("mid_reset", {28'd0, out}, 32'd0);
        check_status("mid_reset", 0);
        @(negedge clock) reset = 1'b1;
        prev = 4'h0;
        edge_check("after_mid", 1);
        check("after_mid_one", {28'd0, out}, 32'd1);

        // Long run: 100 periods against the reference
        for (int unsigned n = 2; n <= 3201; n++) edge_check("long", n);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
